// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute stage.
// The helper op_defined() honours the EX_MUL_EN macro.
package ex_pkg;
    localparam int XLEN_DEF = 64;
    localparam int OPW_DEF  = 4;
    localparam int REGW     = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DONE,
        S_MUL_BUSY
    } state_e;

    // Ops that produce a real result; anything else writes 0 with wen dropped.
    function automatic logic op_defined(input logic [3:0] op);
`ifdef EX_MUL_EN
        return op <= 4'(OP_MUL);
`else
        return op < 4'(OP_MUL);
`endif
    endfunction
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// o_done/o_product are valid together in the final iteration cycle.
module ex_mul_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic            r_busy;
    logic [XLEN-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == CW'(XLEN - 1));
    assign o_product  = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_kill) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_busy   <= !o_done;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage holding one instruction, single-cycle ALU plus
// optional iterative MUL (enabled by macro EX_MUL_EN).
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            ID_valid_i,
    output logic            EX_ready_o,
    input  logic [XLEN-1:0] ID_pc_i,
    input  logic [OPW-1:0]  ID_op_i,
    input  logic [XLEN-1:0] ID_src1_i,
    input  logic [XLEN-1:0] ID_src2_i,
    input  logic [REGW-1:0] ID_rd_i,
    input  logic            ID_wen_i,
    output logic            EX_valid_o,
    input  logic            WB_ready_i,
    output logic [XLEN-1:0] EX_pc_o,
    output logic [XLEN-1:0] EX_result_o,
    output logic [REGW-1:0] EX_rd_o,
    output logic            EX_wen_o
);
    localparam int SW = $clog2(XLEN);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_result;
    logic [REGW-1:0] r_rd;
    logic            r_wen;

    op_e             w_op;
    logic [XLEN-1:0] w_alu;
    logic [SW-1:0]   w_sh;
    logic            w_def;
    logic            w_valid;
    logic            w_accept;

    assign w_op     = op_e'(4'(ID_op_i));
    assign w_sh     = ID_src2_i[SW-1:0];
    assign w_def    = op_defined(4'(ID_op_i));
    assign w_valid  = (r_state == S_DONE);
    assign w_accept = ID_valid_i && EX_ready_o && !flush_i;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = ID_src1_i + ID_src2_i;
            OP_SUB:  w_alu = ID_src1_i - ID_src2_i;
            OP_AND:  w_alu = ID_src1_i & ID_src2_i;
            OP_OR:   w_alu = ID_src1_i | ID_src2_i;
            OP_XOR:  w_alu = ID_src1_i ^ ID_src2_i;
            OP_SLL:  w_alu = ID_src1_i << w_sh;
            OP_SRL:  w_alu = ID_src1_i >> w_sh;
            OP_SRA:  w_alu = $signed(ID_src1_i) >>> w_sh;
            OP_SLT:  w_alu = XLEN'($signed(ID_src1_i) < $signed(ID_src2_i));
            OP_SLTU: w_alu = XLEN'(ID_src1_i < ID_src2_i);
            default: w_alu = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic            w_is_mul;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_prod;

    assign w_is_mul   = (w_op == OP_MUL);
    assign EX_ready_o = (r_state == S_IDLE) || (w_valid && WB_ready_i);

    ex_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept && w_is_mul),
        .i_kill    (flush_i),
        .i_a       (ID_src1_i),
        .i_b       (ID_src2_i),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );
`else
    assign EX_ready_o = !w_valid || WB_ready_i;
`endif

    // Flush outranks accept/transfer; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_result <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_pc     <= ID_pc_i;
            r_rd     <= ID_rd_i;
            r_wen    <= ID_wen_i && w_def;
            r_result <= w_alu;
`ifdef EX_MUL_EN
            r_state  <= w_is_mul ? S_MUL_BUSY : S_DONE;
`else
            r_state  <= S_DONE;
`endif
        end else if (w_valid && WB_ready_i) begin
            r_state <= S_IDLE;
        end
`ifdef EX_MUL_EN
        else if (w_mul_busy && w_mul_done) begin
            r_state  <= S_DONE;
            r_result <= w_mul_prod;
        end
`endif
    end

    assign EX_valid_o  = w_valid;
    assign EX_pc_o     = r_pc;
    assign EX_result_o = r_result;
    assign EX_rd_o     = r_rd;
    assign EX_wen_o    = r_wen && w_valid;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed stimulus with a queue-based reference model of ex_stage
// plus literal checks; covers both EX_MUL_EN builds.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        ID_valid_i;
    logic        EX_ready_o;
    logic [63:0] ID_pc_i;
    logic [3:0]  ID_op_i;
    logic [63:0] ID_src1_i;
    logic [63:0] ID_src2_i;
    logic [4:0]  ID_rd_i;
    logic        ID_wen_i;
    logic        EX_valid_o;
    logic        WB_ready_i;
    logic [63:0] EX_pc_o;
    logic [63:0] EX_result_o;
    logic [4:0]  EX_rd_o;
    logic        EX_wen_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;
    exp_t q[$];

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .ID_valid_i  (ID_valid_i),
        .EX_ready_o  (EX_ready_o),
        .ID_pc_i     (ID_pc_i),
        .ID_op_i     (ID_op_i),
        .ID_src1_i   (ID_src1_i),
        .ID_src2_i   (ID_src2_i),
        .ID_rd_i     (ID_rd_i),
        .ID_wen_i    (ID_wen_i),
        .EX_valid_o  (EX_valid_o),
        .WB_ready_i  (WB_ready_i),
        .EX_pc_o     (EX_pc_o),
        .EX_result_o (EX_result_o),
        .EX_rd_o     (EX_rd_o),
        .EX_wen_o    (EX_wen_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one instruction, written from the op definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] pc, input logic [4:0] rd, input logic wen);
        exp_t e;
        logic known;
        e.pc = pc;
        e.rd = rd;
        known = 1'b1;
        case (op)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = a << b[5:0];
            4'd6: e.res = a >> b[5:0];
            4'd7: e.res = $signed(a) >>> b[5:0];
            4'd8: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: e.res = (a < b) ? 64'd1 : 64'd0;
`ifdef EX_MUL_EN
            4'd10: e.res = a * b;
`endif
            default: begin
                e.res = 64'd0;
                known = 1'b0;
            end
        endcase
        e.wen = wen && known;
        return e;
    endfunction

    // Scoreboard: outputs must match the oldest accepted instruction while valid.
    always @(negedge clk) begin
        if (rst || flush_i) begin
            q.delete();
        end else begin
            if (EX_valid_o) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    chk("sb_result", EX_result_o, q[0].res);
                    chk("sb_pc", EX_pc_o, q[0].pc);
                    chk("sb_rd_wen", {58'd0, EX_rd_o, EX_wen_o}, {58'd0, q[0].rd, q[0].wen});
                    if (WB_ready_i) void'(q.pop_front());
                end
            end else begin
                chk("sb_wen_idle", {63'd0, EX_wen_o}, 64'd0);
            end
            if (ID_valid_i && EX_ready_o)
                q.push_back(model(ID_op_i, ID_src1_i, ID_src2_i, ID_pc_i, ID_rd_i, ID_wen_i));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pc, input logic [4:0] rd, input logic wen);
        ID_valid_i = v;
        ID_op_i    = op;
        ID_src1_i  = a;
        ID_src2_i  = b;
        ID_pc_i    = pc;
        ID_rd_i    = rd;
        ID_wen_i   = wen;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {EX_valid_o, EX_wen_o, EX_rd_o}, 64'd0);
        chk({name, "_pc"}, EX_pc_o, 64'd0);
        chk({name, "_res"}, EX_result_o, 64'd0);
        chk({name, "_rdy"}, {63'd0, EX_ready_o}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int bad;
        rst = 1'b1;
        flush_i = 1'b0;
        WB_ready_i = 1'b1;
        idle();
        tick();
        tick();
        @(negedge clk);
        chk_zero_outputs("reset");
        tick();
        rst = 1'b0;

        // Single ADD
        drive(1'b1, 4'd0, 64'd5, 64'd7, 64'h100, 5'd3, 1'b1);
        @(negedge clk);
        chk("add_rdy_before", {63'd0, EX_ready_o}, 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("add_valid", {63'd0, EX_valid_o}, 64'd1);
        chk("add_result", EX_result_o, 64'd12);
        chk("add_rdy_after", {63'd0, EX_ready_o}, 64'd1);
        tick();

        // Back-to-back stream
        drive(1'b1, 4'd1, 64'd3, 64'd5, 64'h110, 5'd1, 1'b1);
        tick();
        drive(1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h114, 5'd2, 1'b1);
        @(negedge clk);
        chk("b2b_sub", EX_result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        drive(1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h118, 5'd3, 1'b1);
        @(negedge clk);
        chk("b2b_slt", EX_result_o, 64'd1);
        tick();
        drive(1'b1, 4'd7, 64'h8000_0000_0000_0000, 64'd4, 64'h11C, 5'd4, 1'b1);
        @(negedge clk);
        chk("b2b_sltu", EX_result_o, 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("b2b_sra", EX_result_o, 64'hF800_0000_0000_0000);
        chk("b2b_valid", {63'd0, EX_valid_o}, 64'd1);
        tick();

        // WB stall with the next instruction waiting
        drive(1'b1, 4'd0, 64'd10, 64'd20, 64'h200, 5'd2, 1'b1);
        tick();
        WB_ready_i = 1'b0;
        drive(1'b1, 4'd4, 64'hF0, 64'hFF, 64'h210, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy", {63'd0, EX_ready_o}, 64'd0);
            chk("stall_hold", {EX_valid_o, EX_rd_o, EX_wen_o, EX_pc_o[15:0]}, {1'b1, 5'd2, 1'b1, 16'h0200});
            chk("stall_result", EX_result_o, 64'd30);
            tick();
        end
        WB_ready_i = 1'b1;
        @(negedge clk);
        chk("stall_release_rdy", {63'd0, EX_ready_o}, 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("stall_next_result", EX_result_o, 64'h0F);
        chk("stall_next_pc", EX_pc_o, 64'h210);
        tick();

        // Undefined op: result 0, wen dropped
        drive(1'b1, 4'hF, 64'd9, 64'd9, 64'h220, 5'd6, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("undef_op", {EX_valid_o, EX_wen_o, EX_result_o[61:0]}, {1'b1, 1'b0, 62'd0});
        tick();

`ifdef EX_MUL_EN
        // MUL latency and result
        drive(1'b1, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h700, 5'd7, 1'b1);
        tick();
        idle();
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (EX_valid_o) break;
            cnt++;
            if (EX_ready_o) bad++;
            tick();
        end
        chk("mul_latency", 64'(cnt), 64'd64);
        chk("mul_busy_rdy", 64'(bad), 64'd0);
        chk("mul_result", EX_result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        tick();
        // Flush at MUL cycle 20 with a competing instruction
        drive(1'b1, 4'd10, 64'd7, 64'd9, 64'h300, 5'd8, 1'b1);
        tick();
        idle();
        repeat (19) tick();
        @(negedge clk);
        chk("mul_mid_rdy", {63'd0, EX_ready_o}, 64'd0);
`else
        // MUL without the multiplier is a one-cycle undefined op
        drive(1'b1, 4'd10, 64'd6, 64'd7, 64'h700, 5'd7, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("mul_off", {EX_valid_o, EX_wen_o, EX_result_o[61:0]}, {1'b1, 1'b0, 62'd0});
        tick();
        // Flush a held result with a competing instruction
        WB_ready_i = 1'b0;
        drive(1'b1, 4'd0, 64'd7, 64'd9, 64'h300, 5'd8, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("flush_pre_valid", {63'd0, EX_valid_o}, 64'd1);
        WB_ready_i = 1'b1;
`endif
        drive(1'b1, 4'd0, 64'd1, 64'd1, 64'h400, 5'd9, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle();
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (EX_valid_o) cnt++;
            tick();
        end
        chk("flush_no_valid", 64'(cnt), 64'd0);
        chk("flush_no_accept_pc", EX_pc_o, 64'h300);
        drive(1'b1, 4'd0, 64'd1, 64'd2, 64'h500, 5'd10, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("post_flush_add", {EX_valid_o, EX_result_o[62:0]}, {1'b1, 63'd3});
        chk("post_flush_pc", EX_pc_o, 64'h500);
        tick();

        // Reset in the middle of work
`ifdef EX_MUL_EN
        drive(1'b1, 4'd10, 64'd5, 64'd5, 64'h600, 5'd11, 1'b1);
        tick();
        idle();
        repeat (10) tick();
`else
        WB_ready_i = 1'b0;
        drive(1'b1, 4'd0, 64'd5, 64'd5, 64'h600, 5'd11, 1'b1);
        tick();
        idle();
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        WB_ready_i = 1'b1;
        @(negedge clk);
        chk_zero_outputs("mid_reset");
        tick();
        tick();
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage in-order pipe; sits between ID and WB and feeds WB's EX_* inputs.
- Holds one instruction in a pipeline register and computes an XLEN-bit ALU result.
- Single-cycle ops complete in one cycle; MUL runs an iterative shift-add sequence.
- Uses a valid/ready handshake on both sides and supports flush.

Parameters:
- XLEN, 64, datapath width; PC width is also XLEN.
- OPW, 4, width of the op code.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  kill the held instruction, including any MUL in flight
- ID_valid_i  in  1  upstream instruction valid
- EX_ready_o  out  1  EX can accept this cycle
- ID_pc_i  in  XLEN  instruction PC
- ID_op_i  in  OPW  op code (package enum)
- ID_src1_i  in  XLEN  operand 1
- ID_src2_i  in  XLEN  operand 2
- ID_rd_i  in  5  destination register
- ID_wen_i  in  1  register write enable
- EX_valid_o  out  1  result valid to WB
- WB_ready_i  in  1  WB can accept
- EX_pc_o  out  XLEN  held PC
- EX_result_o  out  XLEN  result
- EX_rd_o  out  5  held rd
- EX_wen_o  out  1  held wen, qualified by EX_valid_o

Behaviour:
- Reset:
  - Valid register 0, FSM IDLE, EX_valid_o 0, EX_ready_o 1.
  - EX_pc_o, EX_result_o, EX_rd_o and EX_wen_o all 0.
- FSM states:
  - IDLE: no instruction held.
  - DONE: result ready.
  - MUL_BUSY: multiply iterating.
- Accept: when ID_valid_i && EX_ready_o at a posedge, latch pc, op, src1, src2, rd and wen.
  - Non-MUL op: go to DONE; result registered at the same edge.
  - MUL: go to MUL_BUSY with counter = 0, accumulator = 0, multiplicand = src1, multiplier = src2.
- MUL_BUSY, each cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, counter++.
  - After XLEN iterations, go to DONE with result = low XLEN bits of the product. The product is unsigned mod 2^XLEN, which is sign-agnostic.
  - MUL latency is XLEN+1 cycles from accept to EX_valid_o.
- DONE: EX_valid_o = 1.
  - If WB_ready_i: transfer at that edge.
  - If ID_valid_i is also high, accept the next instruction at the same edge; this gives back-to-back throughput of 1/cycle for ALU ops.
  - Otherwise go to IDLE.
- EX_ready_o = (state==IDLE) || (state==DONE && WB_ready_i). It is combinational and never asserted in MUL_BUSY.
- Output stability: while EX_valid_o && !WB_ready_i, all outputs hold stable.
- ALU ops:
  - ADD/SUB: wrap mod 2^XLEN.
  - AND/OR/XOR: bitwise.
  - SLL/SRL/SRA: shift amount = src2[log2(XLEN)-1:0].
  - SLT (signed) / SLTU: result is 1 or 0, zero-extended.
  - Undefined op: result 0, wen forced 0.
- Flush: flush_i high at a posedge takes priority over everything.
  - Go to IDLE and clear valid; abort any MUL.
  - No accept happens in that cycle, even if ID_valid_i && EX_ready_o.
- rst takes priority over flush_i.
- EX_pc_o is updated only on accept; it holds its value otherwise.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: MUL is implemented as above (MUL_BUSY state, counter, accumulator).
- Undefined:
  - MUL_BUSY and all multiplier registers are absent.
  - MUL is treated as an undefined op: single cycle, result 0, wen 0.
  - EX_ready_o reduces to !valid || WB_ready_i.

Decomposition:
- Package ex_pkg: op enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10), FSM state enum, XLEN default, register-index width 5.
- One sub-module: ex_mul_iter (start, a, b → busy, done, product). It is instantiated only under EX_MUL_EN.
- Combinational ALU stays inline.

Test Plan:
- Reset, then ADD src1=5 src2=7 with WB_ready_i=1 → EX_valid_o=1 next cycle, result=12, EX_ready_o stays 1.
- Back-to-back stream: SUB 3-5, SLT -1<1, SLTU -1<1, SRA 0x8000_0000_0000_0000>>4 → 0xFFFF_FFFF_FFFF_FFFE, 1, 0, 0xF800_0000_0000_0000 on consecutive cycles.
- WB_ready_i low for 3 cycles with result held, while ID_valid_i is high:
  - EX_ready_o=0.
  - Outputs stable for those 3 cycles.
  - Transfer happens on the cycle WB_ready_i rises; the next instruction is accepted at that same edge.
- MUL (EX_MUL_EN) 0xFFFF_FFFF_FFFF_FFFF*3:
  - EX_ready_o=0 for 64 cycles.
  - EX_valid_o rises at cycle 65 with result 0xFFFF_FFFF_FFFF_FFFD.
- flush_i at MUL cycle 20, with ID_valid_i high on the same edge:
  - State goes to IDLE and EX_valid_o never rises.
  - No accept on that edge.
  - Next ADD completes normally.
- rst asserted mid-MUL → all outputs 0 next cycle. Without EX_MUL_EN, a MUL op gives result 0, EX_wen_o=0, one-cycle latency.
